// File: rtl/serial_index_decoder_if.sv
// Index-in / decoded-beat-out handshake bundle for serial_index_decoder.
interface serial_index_decoder_if #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned TOTAL     = 1 << IDX_W;
  localparam int unsigned NUM_WORDS = TOTAL / WORD_W;
  localparam int unsigned WI_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_idx;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [WI_W-1:0]   out_word_idx;
  logic              out_last;

  // Producer of indices / consumer of beats.
  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_word_idx, out_last
  );

  // The decoder itself.
  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_word_idx, out_last
  );
endinterface

// File: rtl/serial_index_decoder.sv
// Word-serial one-hot / thermometer decoder: captures an index, then streams
// the 2^IDX_W-bit decoded vector LSW first, WORD_W bits per beat. Each beat is
// generated on the fly from the captured index and the beat counter.
module serial_index_decoder #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned WORD_W = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_index_decoder_if.slave bus
);
  localparam int unsigned TOTAL     = 1 << IDX_W;
  localparam int unsigned NUM_WORDS = TOTAL / WORD_W;
  localparam int unsigned WI_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state, state_nx;
  logic [WI_W-1:0]   cnt, cnt_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic              mode, mode_nx;

  logic              valid_c;
  logic              last_c;
  logic              ready_c;
  logic [WORD_W-1:0] beat_c;

  // State, beat counter and captured index/mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      mode  <= mode_nx;
    end
  end

  // Next state: accept from IDLE, or chain a new index onto the last beat.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    mode_nx  = mode;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          idx_nx   = bus.in_idx;
          mode_nx  = bus.in_mode;
          cnt_nx   = '0;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (last_c) begin
            cnt_nx = '0;
            if (bus.in_valid) begin
              idx_nx  = bus.in_idx;
              mode_nx = bus.in_mode;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + WI_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state; in_ready also sees out_ready/rst_n.
  always_comb begin
    valid_c = (state == SEND);
    last_c  = valid_c && (cnt == LAST_WORD);
    ready_c = rst_n && (!valid_c || (bus.out_ready && last_c));
    beat_c  = '0;
    if (valid_c) begin
      for (int unsigned j = 0; j < WORD_W; j++) begin
        if (mode) beat_c[j] = ((32'(cnt) * WORD_W + j) <= 32'(idx));
        else      beat_c[j] = ((32'(cnt) * WORD_W + j) == 32'(idx));
      end
    end
  end

  assign bus.out_valid    = valid_c;
  assign bus.out_last     = last_c;
  assign bus.out_data     = beat_c;
  assign bus.out_word_idx = cnt;
  assign bus.in_ready     = ready_c;
endmodule

// File: tb/tb_serial_index_decoder.sv
// Directed bench for serial_index_decoder: default 7/32 instance plus a
// single-beat 7/128 instance for the NUM_WORDS = 1 sweep.
module tb_serial_index_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_index_decoder_if #(.IDX_W(7), .WORD_W(32))  b1 ();
  serial_index_decoder_if #(.IDX_W(7), .WORD_W(128)) b2 ();

  serial_index_decoder #(.IDX_W(7), .WORD_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  serial_index_decoder #(.IDX_W(7), .WORD_W(128)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    b1.in_valid = 1'b1; b1.in_idx = 7'd9; b1.in_mode = 1'b0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_idx = 7'd0; b2.in_mode = 1'b0; b2.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b0 || b1.out_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold c%0d: valid=%b ready=%b data=%h, want 0 0 00000000",
                 c, b1.out_valid, b1.in_ready, b1.out_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; b1.in_valid = 1'b0;
    #1;
    checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || b1.out_word_idx !== 2'd0 ||
        b1.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b widx=%0d last=%b, want 1 0 0 0",
               b1.in_ready, b1.out_valid, b1.out_word_idx, b1.out_last);
    end
  endtask

  task automatic test_onehot_zero();
    logic [31:0] exp [4];
    exp = '{32'h1, 32'h0, 32'h0, 32'h0};
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_idx = 7'd0; b1.in_mode = 1'b0; b1.out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
      #1;
      checks++;
      if (b1.out_data !== exp[w]) begin
        errors++;
        $display("FAIL onehot0_data w%0d: got %h, want %h", w, b1.out_data, exp[w]);
      end
      checks++;
      if ({b1.out_valid, b1.out_word_idx, b1.out_last} !== {1'b1, 2'(w), (w == 3)}) begin
        errors++;
        $display("FAIL onehot0_flags w%0d: valid=%b widx=%0d last=%b, want 1 %0d %0d",
                 w, b1.out_valid, b1.out_word_idx, b1.out_last, w, (w == 3));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL onehot0_after: ready=%b valid=%b, want 1 0", b1.in_ready, b1.out_valid);
    end
  endtask

  task automatic test_thermo();
    logic [31:0] exp [2][4];
    logic [6:0]  idxs [2];
    exp  = '{'{32'hFFFFFFFF, 32'h000001FF, 32'h0, 32'h0},
             '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};
    idxs = '{7'd40, 7'd127};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      b1.in_valid = 1'b1; b1.in_idx = idxs[v]; b1.in_mode = 1'b1; b1.out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        b1.in_valid = 1'b0;
        #1;
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_data !== exp[v][w]) begin
          errors++;
          $display("FAIL thermo idx=%0d w%0d: valid=%b data=%h, want 1 %h",
                   idxs[v], w, b1.out_valid, b1.out_data, exp[v][w]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_idx = 7'd70; b1.in_mode = 1'b0; b1.out_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
      #1;
      checks++;
      if (b1.out_data !== 32'h0 || b1.out_word_idx !== 2'(w) || b1.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_early w%0d: data=%h widx=%0d ready=%b, want 00000000 %0d 0",
                 w, b1.out_data, b1.out_word_idx, b1.in_ready, w);
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      b1.out_ready = (c == 3);
      #1;
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_data !== 32'h40 || b1.out_word_idx !== 2'd2 ||
          b1.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: valid=%b data=%h widx=%0d ready=%b, want 1 00000040 2 0",
                 c, b1.out_valid, b1.out_data, b1.out_word_idx, b1.in_ready);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (b1.out_data !== 32'h0 || b1.out_word_idx !== 2'd3 || b1.out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_last: data=%h widx=%0d last=%b, want 00000000 3 1",
               b1.out_data, b1.out_word_idx, b1.out_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [8];
    exp = '{32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h10};
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_idx = 7'd5; b1.in_mode = 1'b0; b1.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b1.in_idx   = 7'd100;
      b1.in_valid = (c < 4);
      #1;
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_data !== exp[c] || b1.out_word_idx !== 2'(c % 4)) begin
        errors++;
        $display("FAIL b2b c%0d: valid=%b data=%h widx=%0d, want 1 %h %0d",
                 c, b1.out_valid, b1.out_data, b1.out_word_idx, exp[c], c % 4);
      end
      if (c == 3) begin
        checks++;
        if (b1.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_accept: in_ready=%b on last beat, want 1", b1.in_ready);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (b1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b, want 0", b1.out_valid);
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_idx = 7'd3; b1.in_mode = 1'b0; b1.out_ready = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b1.out_word_idx !== 2'd1 || b1.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre: widx=%0d ready=%b, want 1 0", b1.out_word_idx, b1.in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (b1.out_valid !== 1'b0 || b1.out_word_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_abort: valid=%b widx=%0d, want 0 0", b1.out_valid, b1.out_word_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_idx = 7'd33;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
      #1;
      if (w < 2) begin
        checks++;
        if (b1.out_valid !== 1'b1 || b1.out_word_idx !== 2'(w) ||
            b1.out_data !== ((w == 1) ? 32'h2 : 32'h0)) begin
          errors++;
          $display("FAIL mid_restart w%0d: valid=%b widx=%0d data=%h",
                   w, b1.out_valid, b1.out_word_idx, b1.out_data);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [127:0] one;
    logic [127:0] exp;
    logic [127:0] vec;
    logic         flags_ok;
    one = 128'd1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 128; i++) begin
        exp = (m == 1) ? ((i == 127) ? '1 : ((one << (i + 1)) - one)) : (one << i);
        @(negedge clk);
        b1.in_valid = 1'b1; b1.in_idx = 7'(i); b1.in_mode = 1'(m); b1.out_ready = 1'b1;
        flags_ok = 1'b1;
        vec = '0;
        for (int w = 0; w < 4; w++) begin
          @(negedge clk);
          b1.in_valid = 1'b0;
          #1;
          vec[w*32 +: 32] = b1.out_data;
          if (b1.out_valid !== 1'b1 || b1.out_word_idx !== 2'(w)) flags_ok = 1'b0;
        end
        checks++;
        if (vec !== exp || !flags_ok) begin
          errors++;
          $display("FAIL sweep32 mode=%0d idx=%0d: got %h flags_ok=%b, want %h",
                   m, i, vec, flags_ok, exp);
        end
      end
    end
  endtask

  task automatic test_sweep_single_word();
    logic [127:0] one;
    logic [127:0] exp;
    one = 128'd1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 128; i++) begin
        exp = (m == 1) ? ((i == 127) ? '1 : ((one << (i + 1)) - one)) : (one << i);
        @(negedge clk);
        b2.in_valid = 1'b1; b2.in_idx = 7'(i); b2.in_mode = 1'(m); b2.out_ready = 1'b1;
        @(negedge clk);
        b2.in_valid = 1'b0;
        #1;
        checks++;
        if (b2.out_data !== exp || b2.out_valid !== 1'b1 || b2.out_last !== 1'b1 ||
            b2.out_word_idx !== 1'b0) begin
          errors++;
          $display("FAIL sweep128 mode=%0d idx=%0d: got %h v=%b l=%b widx=%0d, want %h 1 1 0",
                   m, i, b2.out_data, b2.out_valid, b2.out_last, b2.out_word_idx, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_zero();
    test_thermo();
    test_backpressure();
    test_back_to_back();
    test_midstream_reset();
    test_sweep();
    test_sweep_single_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_index_decoder.md
# serial_index_decoder

Parametrised, word-serial index decoder. It accepts an IDX_W-bit index over a valid/ready handshake and expands it into a 2^IDX_W-bit vector, either one-hot or thermometer. The vector is streamed out WORD_W bits per beat with its own valid/ready handshake. It replaces the flat combinational 7-to-128 decoder wherever a wide decoded vector has to cross a narrow registered bus.

## Interface
- IDX_W, 7, index width; decoded vector is TOTAL = 2^IDX_W bits
- WORD_W, 32, output beat width; power of two, WORD_W <= TOTAL; NUM_WORDS = TOTAL / WORD_W
- WI_W (derived localparam), max(1, clog2(NUM_WORDS)), word-index width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  index/mode valid
- in_ready  output  1  block can accept an index this cycle
- in_idx  input  IDX_W  index to decode
- in_mode  input  1  0 = one-hot, 1 = thermometer
- out_valid  output  1  out_data holds a valid beat
- out_ready  input  1  sink accepts the beat
- out_data  output  WORD_W  current beat of the decoded vector
- out_word_idx  output  WI_W  beat number, 0 = least-significant word
- out_last  output  1  high on beat NUM_WORDS-1

## Operation
- Vector bit k, for k = 0..TOTAL-1:
  - one-hot: (k == idx)
  - thermometer: (k <= idx); idx = TOTAL-1 gives all ones
- Beat w carries vector bits [w*WORD_W + WORD_W-1 : w*WORD_W].
- Beats are sent in order w = 0, 1, …, NUM_WORDS-1 (LSW first).
- The index and mode are captured in an internal register on acceptance. The full TOTAL-bit vector is never stored; each beat is generated from the captured index and the beat counter.
- FSM, two states:
  - IDLE: out_valid = 0, in_ready = 1. On in_valid: capture in_idx/in_mode, word counter = 0, go to SEND.
  - SEND: out_valid = 1. On out_valid && out_ready with out_last = 0: counter + 1. On handshake with out_last = 1: if in_valid (a new index is accepted the same cycle), capture it, counter = 0, stay in SEND; otherwise go to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready. No other path from inputs to outputs is combinational.
- out_data, out_word_idx and out_last are registered or decoded from registered state only.
- They hold stable while out_valid && !out_ready.
- NUM_WORDS = 1: every beat is last; out_word_idx is constant 0.

## Timing
- Reset (rst_n sampled low at a clk edge):
  - state = IDLE, counter = 0, captured index and mode = 0.
  - out_valid = 0, out_data = 0, out_word_idx = 0, out_last = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 on the first cycle after release.
- An input handshake while rst_n is low is ignored.
- Latency: index accepted at edge N, beat 0 valid in cycle N+1.
- With out_ready held high, the last beat is in cycle N+NUM_WORDS.
- Throughput:
  - with back-to-back inputs, one beat per cycle and no bubble between vectors;
  - from IDLE, one idle cycle between vectors.
- Reset mid-stream aborts the vector:
  - the next cycle shows out_valid = 0 and counter = 0;
  - no partial beats are resumed after release.
- in_idx / in_mode are don't-care when the input handshake does not occur.
- Changing them while SEND is in progress does not affect the current vector.

## Test plan
Defaults (IDX_W = 7, WORD_W = 32) unless noted.

- **Reset:** hold rst_n = 0 for 3 cycles with in_valid = 1 and in_idx = 9.
  - Every cycle: out_valid = 0, in_ready = 0, out_data = 0.
  - First cycle after release: in_ready = 1.
- **One-hot, idx = 0, out_ready = 1:**
  - 4 consecutive beats: 0x00000001, 0x00000000, 0x00000000, 0x00000000.
  - out_word_idx = 0..3; out_last only on beat 3; in_ready = 1 the cycle after.
- **Thermometer:**
  - idx = 40: beats 0xFFFFFFFF, 0x000001FF, 0x00000000, 0x00000000.
  - idx = 127: all four beats 0xFFFFFFFF.
- **Backpressure:** one-hot idx = 70; drop out_ready for 3 cycles while beat 2 is presented.
  - out_data = 0x00000040 and out_word_idx = 2, both stable for all 4 cycles.
  - Beat 3 = 0 follows; in_ready = 0 throughout.
- **Back-to-back:** in_valid held high with one-hot idx = 5 then idx = 100; out_ready = 1.
  - Second index accepted on the out_last beat of the first.
  - 8 consecutive out_valid cycles; beat 3 of the second vector = 0x00000010.
- **Mid-stream reset, plus sweep:**
  - Assert rst_n = 0 for 1 cycle during beat 1; the following cycle shows out_valid = 0.
  - Next accepted index starts at out_word_idx = 0.
  - Then sweep all 128 indices in both modes. Concatenated beats must equal 128'b1 << i (one-hot) or (128'b1 << (i+1)) - 1 with i = 127 → all ones (thermometer).
  - Repeat the sweep with WORD_W = 128 (NUM_WORDS = 1).
